serial_add_ctrl: RTL
====================

// Module: serial_add_ctrl
// PURPOSE
//  Sequencer wrapped around one external add2bit slice (A[1:0], B[1:0], Cin -> S[1:0], CO).
//  Adds or subtracts WIDTH-bit operands two bits per clock, starting at the LSB.
//  Carry passes between slices through an internal register.
//  Drives the slice inputs and consumes the slice outputs, both combinationally.
//  Gives a WIDTH-bit result, a carry flag and a one-cycle done pulse.
// PARAMETERS
//  WIDTH   8   operand/result width; even, >=2; slice count N = WIDTH/2
// PORTS
//  clk         in   1      single clock, rising edge
//  rst         in   1      synchronous reset, active-high
//  start       in   1      request; sampled only in IDLE
//  a_in        in   WIDTH  operand A, latched on accepted start
//  b_in        in   WIDTH  operand B, latched on accepted start
//  op_in       in   1      0 = A+B, 1 = A-B; latched on accepted start
//  slice_a     out  2      to add2bit.A
//  slice_b     out  2      to add2bit.B
//  slice_cin   out  1      to add2bit.Cin
//  slice_s     in   2      from add2bit.S
//  slice_co    in   1      from add2bit.CO
//  busy        out  1      high in RUN
//  done        out  1      one-cycle pulse; result valid
//  result_out  out  WIDTH  sum/difference; held until next accepted start
//  carry_out   out  1      add: carry out; sub: no-borrow (1 iff A>=B unsigned)
// BEHAVIOUR
//  - FSM: IDLE -(start)-> RUN -(N slices done)-> DONE -> IDLE.
//  - Reset: state=IDLE; busy, done, result_out, carry_out, internal shift regs and carry reg = 0.
//  - Accept, at edge E0 in IDLE with start=1:
//      a_sh <= a_in.
//      b_sh <= b_in when op_in=0, ~b_in when op_in=1.
//      carry_reg <= op_in.
//      result_out <= 0; slice counter <= 0.
//  - Slice drive:
//      In RUN: slice_a = a_sh[1:0], slice_b = b_sh[1:0], slice_cin = carry_reg.
//      Outside RUN: all three = 0.
//  - RUN edges E1..EN:
//      Shift {slice_s} in at result MSB end.
//      a_sh and b_sh shift right by 2.
//      carry_reg <= slice_co.
//      Counter increments; at EN, state -> DONE and carry_out <= slice_co.
//  - Latency: done=1 for exactly the cycle after EN (N+1 edges after E0). busy=1 for N cycles.
//  - start while in RUN or DONE: ignored; no queuing.
//  - Operand inputs are don't-care after E0.
//  - rst mid-operation: abort; reset values next cycle; no done pulse.
//  - Width rule: result is modulo 2^WIDTH. No sign extension.
//  - Overflow is reported only by the optional feature.
//  - rst has priority over start on the same edge.
// CONFIGURATION
//  SERIAL_ADD_OVF_EN defined:
//    Extra port ovf_out (out, 1).
//    Set at EN to slice_co XOR carry-into-MSB-of-last-slice (two's-complement overflow).
//    Carry-into-MSB = a1^b1^s1 of the last slice's inputs/outputs.
//    Reset 0; held like result_out.
//  Not defined: port and logic absent. All other behaviour identical.
// TESTING (WIDTH=8, N=4)
//  1. a=100, b=27, op=0 -> result 127, carry 0.
//     busy high 4 cycles; done pulse 5 edges after start.
//  2. a=255, b=1, op=0 -> result 0, carry 1. Verifies the carry ripple across all 4 slices.
//  3. a=5, b=3, op=1 -> result 2, carry 1.
//     a=3, b=5, op=1 -> result 254, carry 0.
//  4. start pulsed again 2 cycles into case 1, with a=1, b=1 -> ignored.
//     Result stays 127; exactly one done pulse.
//  5. rst high at 2nd RUN cycle -> next cycle busy=0, done=0, result=0, state IDLE.
//     New start a=10, b=20 -> 30.
//  6. SERIAL_ADD_OVF_EN: 127+1 -> 128, ovf 1; 200+100 (unsigned) -> 44, carry 1, ovf 0.
//     Exhaustive 4-bit sweep (WIDTH=4) vs a+b / a-b model, no mismatches.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: sequences one external 2-bit adder slice to add/subtract WIDTH-bit operands, LSB first.
// Latency: accept edge E0, then WIDTH/2 RUN edges; done pulses for the single cycle after the last RUN edge.
// Backpressure: none; start is sampled only in IDLE and ignored (not queued) while busy or done.
//
// Ports:
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   start, a_in, b_in, op_in request and operands (op_in 0 = A+B, 1 = A-B), latched on accepted start
//   slice_a/b/cin            drive to the external add2bit slice (zero outside RUN)
//   slice_s/co               sum and carry back from the slice
//   busy, done               busy high in RUN; done one-cycle pulse with result valid
//   result_out, carry_out    result modulo 2^WIDTH; carry (add) or no-borrow (sub)
//   ovf_out                  two's-complement overflow, present only with SERIAL_ADD_OVF_EN defined
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             op_in,
  output logic [1:0]       slice_a,
  output logic [1:0]       slice_b,
  output logic             slice_cin,
  input  logic [1:0]       slice_s,
  input  logic             slice_co,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_out,
  output logic             carry_out
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf_out
`endif
);

  localparam int N  = WIDTH / 2;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry_reg;
  logic [CW-1:0]    cnt;
  logic             accept;
  logic             last_slice;
  logic [WIDTH+1:0] res_shift;

  // New slice sum enters at the MSB end; after N shifts slice 0 sits at the LSB.
  assign res_shift = {slice_s, result_out};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    last_slice = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    slice_a    = 2'b00;
    slice_b    = 2'b00;
    slice_cin  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy      = 1'b1;
        slice_a   = a_sh[1:0];
        slice_b   = b_sh[1:0];
        slice_cin = carry_reg;
        if (cnt == LAST) begin
          last_slice = 1'b1;
          state_nxt  = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh       <= '0;
      b_sh       <= '0;
      carry_reg  <= 1'b0;
      cnt        <= '0;
      result_out <= '0;
      carry_out  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_out    <= 1'b0;
`endif
    end else if (accept) begin
      a_sh       <= a_in;
      // Subtraction is A + ~B + 1: invert B and seed the carry chain with 1.
      b_sh       <= op_in ? ~b_in : b_in;
      carry_reg  <= op_in;
      cnt        <= '0;
      result_out <= '0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_out    <= 1'b0;
`endif
    end else if (state == RUN) begin
      a_sh       <= a_sh >> 2;
      b_sh       <= b_sh >> 2;
      carry_reg  <= slice_co;
      cnt        <= cnt + CW'(1);
      result_out <= res_shift[WIDTH+1:2];
      if (last_slice) begin
        carry_out <= slice_co;
`ifdef SERIAL_ADD_OVF_EN
        // a1^b1^s1 recovers the carry into the MSB of the final slice.
        ovf_out   <= slice_co ^ (slice_a[1] ^ slice_b[1] ^ slice_s[1]);
`endif
      end
    end
  end

endmodule
